spike_count_decoder: RTL and testbench

Output-layer decoder for the spiking network. Sits directly downstream of the output-layer `leaky_integrate_fire` neurons and consumes their `spike_out` bits, one vector per network timestep. Counts spikes per neuron over a programmable window of timesteps, then finds the neuron with the highest count (the classification result). Presents the result on a valid/ready handshake.

---
 rtl/spike_count_decoder.sv | 177 +++++++++++++++++
 tb/tb_spike_count_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_count_decoder.sv
// spike_count_decoder
//   Output-layer decoder for the spiking network. Counts spikes per output
//   neuron over a programmable window of timesteps. It then scans the counts
//   one neuron per cycle to find the winner, which is the classification
//   result. The result is presented on a valid/ready handshake.
//
// Ports
//   clk           in   clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   start         in   begin a new window (sampled in IDLE only)
//   window_len    in   timesteps to collect, latched on start acceptance
//   spike_valid   in   one network timestep; spike_in sampled when high
//   spike_in      in   spike_out bits of the output neurons, bit i = neuron i
//   busy          out  high in every state except IDLE
//   result_valid  out  result available (DONE only)
//   result_ready  in   consumer accepts the result
//   winner_idx    out  index of the neuron with the maximum count
//   winner_count  out  that neuron's count
//   tie           out  another neuron shares the maximum count
module spike_count_decoder #(
  parameter int NUM_NEURONS = 8,
  parameter int CNT_W       = 8,
  parameter int WIN_W       = 8,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [WIN_W-1:0]       window_len,
  input  logic                   spike_valid,
  input  logic [NUM_NEURONS-1:0] spike_in,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_W-1:0]       winner_idx,
  output logic [CNT_W-1:0]       winner_count,
  output logic                   tie
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_SCAN    = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [WIN_W-1:0] r_len;
  logic [WIN_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_count [NUM_NEURONS];

  // Running scan state; copied to the outputs only when the scan ends so the
  // visible result never changes while a new window is in progress.
  logic [IDX_W-1:0] r_scan_idx;
  logic [IDX_W-1:0] r_scan_best;
  logic [CNT_W-1:0] r_scan_max;
  logic             r_scan_tie;

  logic [IDX_W-1:0] r_winner_idx;
  logic [CNT_W-1:0] r_winner_count;
  logic             r_tie;

  logic             w_start_acc;
  logic             w_step;
  logic             w_last_step;
  logic [CNT_W-1:0] w_scan_cur;
  logic [IDX_W-1:0] w_best_nxt;
  logic [CNT_W-1:0] w_max_nxt;
  logic             w_tie_nxt;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_step      = (r_state == ST_COLLECT) && spike_valid;
  assign w_last_step = w_step && (r_step_cnt == r_len - WIN_ONE);
  assign w_scan_cur  = r_count[r_scan_idx];

  // One compare step of the scan. A strictly greater count is needed to
  // displace the current best, so the lowest index wins ties.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    w_best_nxt = r_scan_best;
    w_max_nxt  = r_scan_max;
    w_tie_nxt  = r_scan_tie;
    if (r_scan_idx == '0) begin
      w_best_nxt = '0;
      w_max_nxt  = w_scan_cur;
      w_tie_nxt  = 1'b0;
    end else if (w_scan_cur > r_scan_max) begin
      w_best_nxt = r_scan_idx;
      w_max_nxt  = w_scan_cur;
      w_tie_nxt  = 1'b0;
    end else if (w_scan_cur == r_scan_max) begin
      w_tie_nxt  = 1'b1;
    end
  end

  // Per-neuron saturating spike counters.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the counter array is reset because a reset must discard a partial window entirely.
    if (!reset_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_count[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (w_start_acc) begin
          r_count[i] <= '0;
        end else if (w_step && spike_in[i] && (r_count[i] != '1)) begin
          r_count[i] <= r_count[i] + CNT_ONE;
        end
      end
    end
  end

  // Control FSM, step counter, scan registers and held result.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_len          <= '0;
      r_step_cnt     <= '0;
      r_scan_idx     <= '0;
      r_scan_best    <= '0;
      r_scan_max     <= '0;
      r_scan_tie     <= 1'b0;
      r_winner_idx   <= '0;
      r_winner_count <= '0;
      r_tie          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len       <= window_len;
            r_step_cnt  <= '0;
            r_scan_idx  <= '0;
            r_scan_best <= '0;
            r_scan_max  <= '0;
            r_scan_tie  <= 1'b0;
            // A zero-length window has nothing to collect.
            r_state     <= (window_len != '0) ? ST_COLLECT : ST_SCAN;
          end
        end
        ST_COLLECT: begin
          if (w_step) begin
            r_step_cnt <= r_step_cnt + WIN_ONE;
            if (w_last_step) r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_scan_best <= w_best_nxt;
          r_scan_max  <= w_max_nxt;
          r_scan_tie  <= w_tie_nxt;
          if (r_scan_idx == LAST_IDX) begin
            r_scan_idx     <= '0;
            r_winner_idx   <= w_best_nxt;
            r_winner_count <= w_max_nxt;
            r_tie          <= w_tie_nxt;
            r_state        <= ST_DONE;
          end else begin
            r_scan_idx <= r_scan_idx + IDX_ONE;
          end
        end
        ST_DONE: begin
          if (result_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != ST_IDLE);
  assign result_valid = (r_state == ST_DONE);
  assign winner_idx   = r_winner_idx;
  assign winner_count = r_winner_count;
  assign tie          = r_tie;

endmodule

// File: tb/tb_spike_count_decoder.sv
// tb_spike_count_decoder
//   Directed bench for spike_count_decoder. Two instances share one stimulus
//   stream: dut uses the default 8-bit counters, dut_sat uses 4-bit counters
//   to exercise saturation. Expected values are hand-computed per vector.
module tb_spike_count_decoder;

  localparam int N = 8;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] window_len;
  logic       spike_valid;
  logic [7:0] spike_in;
  logic       result_ready;

  logic       busy, result_valid, tie;
  logic [2:0] winner_idx;
  logic [7:0] winner_count;

  logic       s_busy, s_result_valid, s_tie;
  logic [2:0] s_winner_idx;
  logic [3:0] s_winner_count;

  int n_chk = 0;
  int n_bad = 0;

  spike_count_decoder #(.NUM_NEURONS(N), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .window_len(window_len),
    .spike_valid(spike_valid), .spike_in(spike_in), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .winner_idx(winner_idx), .winner_count(winner_count), .tie(tie)
  );

  spike_count_decoder #(.NUM_NEURONS(N), .CNT_W(4), .WIN_W(8)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .window_len(window_len),
    .spike_valid(spike_valid), .spike_in(spike_in), .busy(s_busy),
    .result_valid(s_result_valid), .result_ready(result_ready),
    .winner_idx(s_winner_idx), .winner_count(s_winner_count), .tie(s_tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    start      = 1'b1;
    window_len = len;
    tick();
    start      = 1'b0;
  endtask

  task automatic spike(input logic [7:0] v);
    spike_valid = 1'b1;
    spike_in    = v;
    tick();
    spike_valid = 1'b0;
    spike_in    = 8'h00;
  endtask

  // Counts cycles until result_valid; an exhausted budget is a failure.
  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 200) begin
      tick();
      n++;
    end
    if (!result_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("acc_valid", result_valid, 0);
    check("acc_busy", busy, 0);
  endtask

  int n;

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    window_len   = 8'd0;
    spike_valid  = 1'b0;
    spike_in     = 8'h00;
    result_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_idx", winner_idx, 0);
    check("rst_cnt", winner_count, 0);
    check("rst_tie", tie, 0);
    reset_n = 1'b1;
    tick();

    // 1. Basic window: n2=4, n0=1, n7=1.
    do_start(8'd4);
    check("t1_busy", busy, 1);
    spike(8'h05);
    spike(8'h04);
    spike(8'h84);
    spike(8'h04);
    check("t1_scan_valid", result_valid, 0);
    wait_valid(n);
    check("t1_latency", n + 1, 9);
    check("t1_idx", winner_idx, 2);
    check("t1_cnt", winner_count, 4);
    check("t1_tie", tie, 0);
    check("t1_sat_cnt", s_winner_count, 4);
    accept();

    // 2. Tie with 2-cycle gaps between steps: n0=n3=2.
    do_start(8'd3);
    spike(8'h09);
    tick();
    tick();
    spike(8'h09);
    tick();
    tick();
    check("t2_gap_busy", busy, 1);
    check("t2_gap_valid", result_valid, 0);
    spike(8'h00);
    check("t2_hold_idx", winner_idx, 2);
    check("t2_hold_cnt", winner_count, 4);
    wait_valid(n);
    check("t2_latency", n + 1, 9);
    check("t2_idx", winner_idx, 0);
    check("t2_cnt", winner_count, 2);
    check("t2_tie", tie, 1);
    accept();

    // 3. Saturation: 20 steps of neuron 6.
    do_start(8'd20);
    for (int i = 0; i < 20; i++) spike(8'h40);
    wait_valid(n);
    check("t3_sat_valid", s_result_valid, 1);
    check("t3_sat_idx", s_winner_idx, 6);
    check("t3_sat_cnt", s_winner_count, 15);
    check("t3_sat_tie", s_tie, 0);
    check("t3_idx", winner_idx, 6);
    check("t3_cnt", winner_count, 20);
    check("t3_tie", tie, 0);
    accept();

    // 4. Zero window, stray start/spike_valid in SCAN and DONE.
    do_start(8'd0);
    spike_valid = 1'b1;
    spike_in    = 8'hFF;
    start       = 1'b1;
    window_len  = 8'd5;
    tick();
    tick();
    spike_valid = 1'b0;
    spike_in    = 8'h00;
    start       = 1'b0;
    wait_valid(n);
    check("t4_latency", n + 2, 8);
    check("t4_idx", winner_idx, 0);
    check("t4_cnt", winner_count, 0);
    check("t4_tie", tie, 1);
    spike_valid = 1'b1;
    spike_in    = 8'hFF;
    start       = 1'b1;
    tick();
    tick();
    spike_valid = 1'b0;
    spike_in    = 8'h00;
    start       = 1'b0;
    check("t4_done_valid", result_valid, 1);
    check("t4_done_cnt", winner_count, 0);
    check("t4_done_tie", tie, 1);
    accept();

    // 5. Backpressure, then back-to-back start.
    do_start(8'd1);
    spike(8'h08);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      check("t5_stall_valid", result_valid, 1);
      check("t5_stall_idx", winner_idx, 3);
      check("t5_stall_cnt", winner_count, 1);
      check("t5_stall_tie", tie, 0);
      tick();
    end
    accept();
    do_start(8'd0);
    check("t5_b2b_busy", busy, 1);
    wait_valid(n);
    check("t5_b2b_latency", n + 1, 9);
    check("t5_b2b_tie", tie, 1);
    accept();

    // 6. Reset mid-window, then a fresh 1-step window.
    do_start(8'd5);
    spike(8'hFF);
    spike(8'hFF);
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", result_valid, 0);
    check("t6_rst_idx", winner_idx, 0);
    check("t6_rst_cnt", winner_count, 0);
    check("t6_rst_tie", tie, 0);
    tick();
    reset_n = 1'b1;
    tick();
    do_start(8'd1);
    spike(8'h10);
    wait_valid(n);
    check("t6_latency", n + 1, 9);
    check("t6_idx", winner_idx, 4);
    check("t6_cnt", winner_count, 1);
    check("t6_tie", tie, 0);
    accept();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
